game_step_ctrl: RTL and testbench
=================================

Name: game_step_ctrl

Overview:
Sequencer for one 2048 game step. It runs the fill unit (fillEmptyCellBySeq), then tries the four move directions in a latched priority order against the combinational merge datapath (mergeBoard). It commits the first movable result to the board RAM, or flags the board as stuck. It sits between the top-level game control and the fill, merge and RAM blocks, replacing ad-hoc sequencing in the top.

Parameters:
SETTLE_CYCLES, 1, extra cycles mov_dir is held before movable is sampled (merge path settle); legal range 0..7
FILL_TIMEOUT, 64, maximum cycles spent waiting for fill_done before aborting; 0 disables the timeout
MOVE_CNT_W, 16, width of the committed-move counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge)
start  in  1  request one game step; sampled only in IDLE
mov_seq  in  8  four 2-bit directions, priority 0 in [1:0], priority 3 in [7:6]; latched on accepted start
fill_done  in  1  fill unit finished
movable  in  1  merge datapath reports mov_dir changes the board
fill_rst  out  1  reset to the fill unit; high = hold in reset
mov_dir  out  2  direction presented to the merge datapath
ram_we  out  1  one-cycle write strobe to the board RAM (merged board is captured)
busy  out  1  step in progress
calc_done  out  1  one-cycle pulse at the end of every step (success, stuck or error)
stuck  out  1  no direction was movable; sticky
fill_err  out  1  fill timeout; sticky
move_count  out  MOVE_CNT_W  number of committed moves

Behaviour:
- Reset values (rst=0): state=IDLE, fill_rst=1, mov_dir=0, ram_we=0, busy=0, calc_done=0, stuck=0, fill_err=0, move_count=0, latched sequence=0, direction index=0, counters=0.
- Reset mid-step aborts the step immediately. No ram_we or calc_done is produced for the aborted step.
- States: IDLE, FILL_START, FILL_WAIT, TRY, COMMIT, DONE, STUCK, ERR.
- IDLE: fill_rst=1, busy=0. If start=1: latch mov_seq, clear stuck and fill_err, go to FILL_START. If start=0, stay.
- FILL_START (1 cycle): fill_rst=1, busy=1. Any fill_done seen in this cycle is stale and ignored. Go to FILL_WAIT.
- FILL_WAIT: fill_rst=0.
  - fill_done=1: set index=0, clear the settle counter, go to TRY.
  - Otherwise the wait counter increments. If FILL_TIMEOUT≠0 and the counter reaches FILL_TIMEOUT, go to ERR.
- TRY: fill_rst=0 and mov_dir=seq[2*index+1:2*index]. Each direction occupies SETTLE_CYCLES+1 cycles, and movable is sampled only in the last of them.
  - movable=1: go to COMMIT.
  - movable=0 and index<3: increment index, clear the settle counter, stay in TRY.
  - movable=0 and index=3: go to STUCK.
- COMMIT (1 cycle): ram_we=1, mov_dir held. Go to DONE.
- DONE (1 cycle): calc_done=1. move_count increments and saturates at all-ones. Go to IDLE.
- STUCK (1 cycle): stuck=1 (held until next accepted start or reset), calc_done=1, ram_we stays 0. Go to IDLE.
- ERR (1 cycle): fill_err=1 (sticky like stuck), calc_done=1, ram_we=0. Go to IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored and is not queued.
- start asserted in the same cycle calc_done pulses is ignored, because the FSM is not yet in IDLE. It is accepted on the following cycle.
- mov_dir holds its last value in IDLE.
- Duplicate directions in mov_seq are legal and are tried again as given.
- Latency with fill_done=1 immediately in FILL_WAIT, success on direction k (0..3): start sampled at cycle 0, ram_we at cycle 3+(k+1)(SETTLE_CYCLES+1), calc_done one cycle later.
- Only one of ram_we, stuck-set or fill_err-set can occur per step.

Test Plan:
1. Reset with start=1 held, rst=0 for 2 cycles -> all outputs at reset values, fill_rst=1; after release, start accepted in the first cycle with rst=1.
2. mov_seq=8'b11_10_01_00, fill_done high from cycle 2, movable=1 for dir 0, SETTLE_CYCLES=1 -> ram_we at cycle 5, calc_done at cycle 6, mov_dir=0, move_count=1, stuck=0.
3. Same seq, movable only when mov_dir=2 -> mov_dir steps 0,1,2 (2 cycles each); one ram_we with mov_dir=2; move_count increments.
4. movable never asserted -> all four directions tried, no ram_we, stuck=1 and calc_done pulse; the next start clears stuck.
5. fill_done never asserted, FILL_TIMEOUT=64 -> fill_err=1 and calc_done exactly 64 cycles after entering FILL_WAIT, no ram_we; a stale fill_done in FILL_START is ignored.
6. start pulsed during TRY, then rst=0 mid-TRY -> the extra start is ignored; reset yields no ram_we or calc_done; move_count=0 and MOVE_CNT_W=2 saturates at 3 after 5 successful steps.

Source files
------------

// File: rtl/game_step_ctrl.sv
`default_nettype none
// game_step_ctrl: runs fill, then tries four move directions in latched priority order,
// committing the first movable board or flagging the board stuck. Revision 1.0
module game_step_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FILL_TIMEOUT  = 64,
  parameter int MOVE_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            mov_seq,
  input  logic                  fill_done,
  input  logic                  movable,
  output logic                  fill_rst,
  output logic [1:0]            mov_dir,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  calc_done,
  output logic                  stuck,
  output logic                  fill_err,
  output logic [MOVE_CNT_W-1:0] move_count
);

  localparam int              WAIT_W    = (FILL_TIMEOUT < 2) ? 1 : $clog2(FILL_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(FILL_TIMEOUT);
  localparam logic [2:0]      SETTLE_V  = 3'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL_START, S_FILL_WAIT, S_TRY, S_COMMIT, S_DONE, S_STUCK, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              seq_q, seq_d;
  logic [1:0]              idx_q, idx_d;
  logic [2:0]              settle_q, settle_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [WAIT_W:0]         wait_inc;
  logic                    fill_rst_q, fill_rst_d;
  logic [1:0]              mov_dir_q, mov_dir_d;
  logic                    ram_we_q, ram_we_d;
  logic                    busy_q, busy_d;
  logic                    calc_done_q, calc_done_d;
  logic                    stuck_q, stuck_d;
  logic                    fill_err_q, fill_err_d;
  logic [MOVE_CNT_W-1:0]   move_count_q, move_count_d;

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    wait_d       = wait_q;
    stuck_d      = stuck_q;
    fill_err_d   = fill_err_q;
    move_count_d = move_count_q;
    wait_inc     = {1'b0, wait_q} + (WAIT_W + 1)'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_d      = mov_seq;
          stuck_d    = 1'b0;
          fill_err_d = 1'b0;
          state_d    = S_FILL_START;
        end
      end
      S_FILL_START: begin
        wait_d  = '0;
        state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (fill_done) begin
          idx_d    = 2'd0;
          settle_d = 3'd0;
          state_d  = S_TRY;
        end else if (FILL_TIMEOUT != 0) begin
          wait_d = wait_inc[WAIT_W-1:0];
          if (wait_inc == TIMEOUT_V) begin
            fill_err_d = 1'b1;
            state_d    = S_ERR;
          end
        end
      end
      S_TRY: begin
        // movable is only trusted in the last settle cycle of each direction
        if (settle_q != SETTLE_V) begin
          settle_d = settle_q + 3'd1;
        end else if (movable) begin
          state_d = S_COMMIT;
        end else if (idx_q != 2'd3) begin
          idx_d    = idx_q + 2'd1;
          settle_d = 3'd0;
        end else begin
          stuck_d = 1'b1;
          state_d = S_STUCK;
        end
      end
      S_COMMIT: begin
        if (move_count_q != {MOVE_CNT_W{1'b1}}) move_count_d = move_count_q + MOVE_CNT_W'(1);
        state_d = S_DONE;
      end
      S_DONE, S_STUCK, S_ERR: state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they align with it
    fill_rst_d  = !(state_d inside {S_FILL_WAIT, S_TRY, S_COMMIT});
    mov_dir_d   = (state_d == S_TRY) ? seq_d[{idx_d, 1'b0} +: 2] : mov_dir_q;
    ram_we_d    = (state_d == S_COMMIT);
    busy_d      = (state_d != S_IDLE);
    calc_done_d = (state_d inside {S_DONE, S_STUCK, S_ERR});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      seq_q        <= 8'd0;
      idx_q        <= 2'd0;
      settle_q     <= 3'd0;
      wait_q       <= '0;
      fill_rst_q   <= 1'b1;
      mov_dir_q    <= 2'd0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      calc_done_q  <= 1'b0;
      stuck_q      <= 1'b0;
      fill_err_q   <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      wait_q       <= wait_d;
      fill_rst_q   <= fill_rst_d;
      mov_dir_q    <= mov_dir_d;
      ram_we_q     <= ram_we_d;
      busy_q       <= busy_d;
      calc_done_q  <= calc_done_d;
      stuck_q      <= stuck_d;
      fill_err_q   <= fill_err_d;
      move_count_q <= move_count_d;
    end
  end

  assign fill_rst   = fill_rst_q;
  assign mov_dir    = mov_dir_q;
  assign ram_we     = ram_we_q;
  assign busy       = busy_q;
  assign calc_done  = calc_done_q;
  assign stuck      = stuck_q;
  assign fill_err   = fill_err_q;
  assign move_count = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_step_ctrl.sv
`default_nettype none
// tb_game_step_ctrl: directed steps against a scoreboard of expected step outcomes.
// Revision 1.0
module tb_game_step_ctrl;

  localparam int SETTLE  = 1;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 2;
  localparam int P       = SETTLE + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       mov_seq;
  logic             fill_done;
  logic             movable;
  logic             fill_rst;
  logic [1:0]       mov_dir;
  logic             ram_we;
  logic             busy;
  logic             calc_done;
  logic             stuck;
  logic             fill_err;
  logic [CNT_W-1:0] move_count;

  logic [3:0] mask_cur;

  typedef struct {
    int         done_cyc;
    int         we_cyc;
    int         n_we;
    logic [1:0] dir;
    logic       stuck;
    logic       err;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  int   exp_cnt = 0;

  game_step_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .FILL_TIMEOUT (TIMEOUT),
    .MOVE_CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mov_seq   (mov_seq),
    .fill_done (fill_done),
    .movable   (movable),
    .fill_rst  (fill_rst),
    .mov_dir   (mov_dir),
    .ram_we    (ram_we),
    .busy      (busy),
    .calc_done (calc_done),
    .stuck     (stuck),
    .fill_err  (fill_err),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  // merge datapath model: the board moves only in the directions set in mask_cur
  assign movable = mask_cur[mov_dir];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_step(input logic [7:0] seq, input logic [3:0] mask,
                          input bit stale_fill, input bit restart);
    exp_t       e;
    int         k;
    int         dc, wc, nwe;
    logic [1:0] wd;

    e.we_cyc = -1; e.n_we = 0; e.dir = 2'd0; e.stuck = 1'b0; e.err = 1'b0;
    if (stale_fill) begin
      e.err      = 1'b1;
      e.done_cyc = 2 + TIMEOUT;
    end else begin
      k = -1;
      for (int j = 0; j < 4; j++) if (k < 0 && mask[seq[2*j +: 2]]) k = j;
      if (k < 0) begin
        e.stuck    = 1'b1;
        e.done_cyc = 3 + 4 * P;
      end else begin
        e.we_cyc   = 3 + (k + 1) * P;
        e.done_cyc = e.we_cyc + 1;
        e.n_we     = 1;
        e.dir      = seq[2*k +: 2];
        if (exp_cnt < 3) exp_cnt++;
      end
    end
    e.cnt = 2'(exp_cnt);
    sb.push_back(e);

    mask_cur = mask; mov_seq = seq; fill_done = 1'b1; start = 1'b1;
    tick(); cyc = 1; start = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("fill_rst_in_fill_start", fill_rst, 1);
    chk("flags_cleared_on_accept", {stuck, fill_err}, 0);

    dc = -1; wc = -1; nwe = 0; wd = 2'd0;
    for (int i = 0; i < 200 && dc < 0; i++) begin
      if (ram_we) begin nwe++; wc = cyc; wd = mov_dir; end
      if (calc_done) dc = cyc;
      else begin
        tick(); cyc++;
        if (stale_fill && cyc == 2) fill_done = 1'b0;
      end
    end

    e = sb.pop_front();
    chk("calc_done_cycle", dc, e.done_cyc);
    chk("ram_we_count", nwe, e.n_we);
    chk("ram_we_cycle", wc, e.we_cyc);
    if (e.n_we != 0) chk("commit_dir", wd, e.dir);

    if (restart) begin
      start = 1'b1;
      tick();
      chk("start_at_done_ignored", busy, 0);
    end else begin
      tick();
      chk("idle_after_step", {busy, calc_done, ram_we}, 0);
    end
    chk("stuck_flag", stuck, e.stuck);
    chk("fill_err_flag", fill_err, e.err);
    chk("move_count", move_count, e.cnt);
  endtask

  initial begin
    int evt;

    // reset with start held high
    rst = 1'b0; start = 1'b1; mov_seq = 8'he4; fill_done = 1'b0; mask_cur = 4'b0000;
    tick(); tick();
    chk("rst_fill_rst", fill_rst, 1);
    chk("rst_mov_dir", mov_dir, 0);
    chk("rst_strobes", {ram_we, calc_done, busy}, 0);
    chk("rst_flags", {stuck, fill_err}, 0);
    chk("rst_move_count", move_count, 0);
    rst = 1'b1;

    run_step(8'b11_10_01_00, 4'b0001, 1'b0, 1'b0);  // first direction moves
    run_step(8'b11_10_01_00, 4'b0100, 1'b0, 1'b0);  // third direction moves
    run_step(8'b11_10_01_00, 4'b0000, 1'b0, 1'b1);  // stuck, start during calc_done
    run_step(8'b00_00_00_11, 4'b1000, 1'b0, 1'b0);  // clears stuck, counter reaches 3
    run_step(8'b10_01_01_01, 4'b0100, 1'b0, 1'b0);  // duplicates retried, saturated count
    run_step(8'b11_10_01_00, 4'b0001, 1'b1, 1'b0);  // stale fill_done then timeout

    // abort mid-TRY with a stray start in between
    evt = 0;
    mask_cur = 4'b0000; mov_seq = 8'he4; fill_done = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); evt += int'(ram_we) + int'(calc_done); end
    start = 1'b1;
    tick(); start = 1'b0; evt += int'(ram_we) + int'(calc_done);
    chk("busy_during_try", busy, 1);
    tick(); evt += int'(ram_we) + int'(calc_done);
    rst = 1'b0;
    tick(); evt += int'(ram_we) + int'(calc_done);
    chk("abort_no_strobes", evt, 0);
    chk("abort_reset_state", {busy, fill_rst, mov_dir, stuck, fill_err}, 6'b010000);
    chk("abort_move_count", move_count, 0);
    rst = 1'b1;
    tick();
    chk("stray_start_not_queued", busy, 0);
    exp_cnt = 0;

    for (int i = 0; i < 5; i++) run_step(8'he4, 4'(1 << (i % 4)), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
